// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state, opcode and mux encodings for the multicycle controller (CTRL_ILLEGAL_TRAP_EN adds TRAP)
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP    = 4'd11
`endif
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] SRC_A_RS1    = 2'd2;

  localparam logic [1:0] SRC_B_RS2    = 2'd0;
  localparam logic [1:0] SRC_B_IMM    = 2'd1;
  localparam logic [1:0] SRC_B_FOUR   = 2'd2;

  localparam logic [1:0] ALU_ADD      = 2'd0;
  localparam logic [1:0] ALU_SUB      = 2'd1;
  localparam logic [1:0] ALU_FUNCT    = 2'd2;

  localparam logic [1:0] RES_ALU_OUT  = 2'd0;
  localparam logic [1:0] RES_MEM      = 2'd1;
  localparam logic [1:0] RES_ALU      = 2'd2;

endpackage

// File: rtl/ctrl_next_state.sv
// rtl/ctrl_next_state.sv - combinational next-state decode (CTRL_ILLEGAL_TRAP_EN routes illegal opcodes to TRAP)
module ctrl_next_state
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic [3:0] next_state
);

  state_t ns;

  // Sequence the instruction phases; memory states hold until the access completes
  always_comb begin
    ns = S_FETCH;
    case (state_t'(state))
      S_FETCH:     ns = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: ns = S_MEM_ADR;
          OP_R:         ns = S_EXEC_R;
          OP_I:         ns = S_EXEC_I;
          OP_BRANCH:    ns = S_BRANCH;
          OP_JAL:       ns = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      ns = S_TRAP;
`else
          default:      ns = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADR:   ns = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  ns = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    ns = S_FETCH;
      S_MEM_WRITE: ns = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    ns = S_ALU_WB;
      S_EXEC_I:    ns = S_ALU_WB;
      S_ALU_WB:    ns = S_FETCH;
      S_BRANCH:    ns = S_FETCH;
      S_JAL:       ns = S_ALU_WB;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:      ns = S_TRAP;
`endif
      default:     ns = S_FETCH;
    endcase
  end

  assign next_state = ns;

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for the multicycle RV32I core (CTRL_ILLEGAL_TRAP_EN enables the trap state)
module multicycle_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  state_t     state;
  logic [3:0] next_state;
  logic       illegal_q;
  logic       unused_funct3;

  // Only funct3[0] distinguishes BEQ from BNE
  assign unused_funct3 = ^funct3[2:1];

  ctrl_next_state u_next_state (
    .state      (state),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .next_state (next_state)
  );

  // State register; reset always lands in FETCH, abandoning any memory access
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_t'(next_state);
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Sticky flag raised on the same edge that enters TRAP
  always_ff @(posedge clk) begin
    if (reset)
      illegal_q <= 1'b0;
    else if (state == S_DECODE && next_state == S_TRAP)
      illegal_q <= 1'b1;
  end
`else
  assign illegal_q = 1'b0;
`endif

  // State-decoded outputs; reset forces everything low so no write leaks in the reset cycle
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALU_OUT;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_a  = SRC_A_PC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
        end
        S_MEM_ADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEM_WB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          alu_op    = ALU_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_FUNCT;
        end
        S_ALU_WB: begin
          result_src = RES_ALU_OUT;
          reg_write  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_RS2;
          alu_op     = ALU_SUB;
          result_src = RES_ALU_OUT;
          pc_write   = zero ^ funct3[0];
        end
        S_JAL: begin
          alu_src_a  = SRC_A_OLD_PC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU_OUT;
          pc_write   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal_instr = illegal_q & ~reset;
  assign state_dbg     = reset ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       ir_write, pc_write, adr_src, mem_req, mem_we, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       illegal_instr;
  logic [3:0] state_dbg;

  int passes = 0;
  int total  = 0;

  multicycle_controller dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct3        (funct3),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .result_src    (result_src),
    .illegal_instr (illegal_instr),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = OP_R; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
    tick; tick;
    chk("rst_state", state_dbg, 4'd0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_ir_write", ir_write, 1'b0);
    chk("rst_pc_write", pc_write, 1'b0);
    chk("rst_illegal", illegal_instr, 1'b0);

    // R-type: FETCH, DECODE, EXEC_R, ALU_WB
    reset = 1'b0; #1;
    chk("r_c1_state", state_dbg, 4'd0);
    chk("r_c1_ir_write", ir_write, 1'b1);
    chk("r_c1_pc_write", pc_write, 1'b1);
    chk("r_c1_mem_req", mem_req, 1'b1);
    chk("r_c1_src_b", alu_src_b, 2'd2);
    chk("r_c1_result", result_src, 2'd2);
    tick;
    chk("r_c2_state", state_dbg, 4'd1);
    chk("r_c2_ir_write", ir_write, 1'b0);
    chk("r_c2_src_a", alu_src_a, 2'd1);
    chk("r_c2_src_b", alu_src_b, 2'd1);
    tick;
    chk("r_c3_state", state_dbg, 4'd6);
    chk("r_c3_alu_op", alu_op, 2'd2);
    chk("r_c3_src_a", alu_src_a, 2'd2);
    chk("r_c3_reg_write", reg_write, 1'b0);
    tick;
    chk("r_c4_state", state_dbg, 4'd8);
    chk("r_c4_reg_write", reg_write, 1'b1);
    chk("r_c4_ir_write", ir_write, 1'b0);
    tick;
    chk("r_c5_state", state_dbg, 4'd0);

    // LW with two wait cycles in MEM_READ
    opcode = OP_LW; #1;
    tick;
    chk("lw_c2_state", state_dbg, 4'd1);
    tick;
    chk("lw_c3_state", state_dbg, 4'd2);
    chk("lw_c3_src_a", alu_src_a, 2'd2);
    tick;
    mem_ready = 1'b0; #1;
    chk("lw_c4_state", state_dbg, 4'd3);
    chk("lw_c4_req", mem_req, 1'b1);
    chk("lw_c4_adr", adr_src, 1'b1);
    tick;
    chk("lw_c5_state", state_dbg, 4'd3);
    chk("lw_c5_req", mem_req, 1'b1);
    chk("lw_c5_adr", adr_src, 1'b1);
    chk("lw_c5_we", mem_we, 1'b0);
    tick;
    mem_ready = 1'b1; #1;
    chk("lw_c6_state", state_dbg, 4'd3);
    chk("lw_c6_req", mem_req, 1'b1);
    chk("lw_c6_adr", adr_src, 1'b1);
    tick;
    chk("lw_c7_state", state_dbg, 4'd4);
    chk("lw_c7_result", result_src, 2'd1);
    chk("lw_c7_reg_write", reg_write, 1'b1);
    tick;
    chk("lw_c8_state", state_dbg, 4'd0);

    // BEQ taken, BNE not taken, both with zero=1
    opcode = OP_BRANCH; funct3 = 3'b000; zero = 1'b1; #1;
    tick; tick;
    chk("beq_state", state_dbg, 4'd9);
    chk("beq_pc_write", pc_write, 1'b1);
    chk("beq_alu_op", alu_op, 2'd1);
    tick;
    chk("beq_back_fetch", state_dbg, 4'd0);
    funct3 = 3'b001; #1;
    tick; tick;
    chk("bne_state", state_dbg, 4'd9);
    chk("bne_pc_write", pc_write, 1'b0);
    zero = 1'b0; #1;
    chk("bne_nz_pc_write", pc_write, 1'b1);
    tick;

    // JAL: four cycles
    opcode = OP_JAL; funct3 = 3'd0; #1;
    tick; tick;
    chk("jal_state", state_dbg, 4'd10);
    chk("jal_pc_write", pc_write, 1'b1);
    chk("jal_src_a", alu_src_a, 2'd1);
    chk("jal_src_b", alu_src_b, 2'd2);
    tick;
    chk("jal_wb_state", state_dbg, 4'd8);
    chk("jal_wb_reg_write", reg_write, 1'b1);
    tick;
    chk("jal_done_state", state_dbg, 4'd0);

    // FETCH wait state: no writes, stays put
    mem_ready = 1'b0; #1;
    chk("fw_ir_write", ir_write, 1'b0);
    chk("fw_pc_write", pc_write, 1'b0);
    tick;
    chk("fw_state", state_dbg, 4'd0);
    chk("fw_req", mem_req, 1'b1);
    mem_ready = 1'b1;

    // SW interrupted by reset during MEM_WRITE
    opcode = OP_SW; #1;
    tick; tick; tick;
    mem_ready = 1'b0; #1;
    chk("sw_state", state_dbg, 4'd5);
    chk("sw_we", mem_we, 1'b1);
    chk("sw_req", mem_req, 1'b1);
    reset = 1'b1; #1;
    chk("sw_rst_we", mem_we, 1'b0);
    chk("sw_rst_req", mem_req, 1'b0);
    chk("sw_rst_state", state_dbg, 4'd0);
    tick;
    reset = 1'b0; mem_ready = 1'b1; #1;
    chk("sw_after_state", state_dbg, 4'd0);
    chk("sw_after_req", mem_req, 1'b1);
    chk("sw_after_we", mem_we, 1'b0);

    // Illegal opcode
    opcode = 7'b1111111; #1;
    tick;
    chk("ill_decode_state", state_dbg, 4'd1);
    chk("ill_decode_pc_write", pc_write, 1'b0);
    tick;
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_trap_state", state_dbg, 4'd11);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("ill_trap_req", mem_req, 1'b0);
      chk("ill_trap_pc_write", pc_write, 1'b0);
      chk("ill_flag", illegal_instr, 1'b1);
    end
    chk("ill_trap_hold", state_dbg, 4'd11);
`else
    chk("ill_nop_state", state_dbg, 4'd0);
    chk("ill_flag", illegal_instr, 1'b0);
    chk("ill_nop_req", mem_req, 1'b1);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback, and drives the instruction register's `ir_write` together with the PC, memory, register-file and ALU-mux controls. The datapath supplies the opcode and funct3 fields from the latched instruction, the ALU zero flag, and the memory-ready handshake.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  7  instruction register bits [6:0].
- `funct3`  in  3  instruction register bits [14:12].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `ir_write`  out  1  instruction register load enable.
- `pc_write`  out  1  PC load enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALU-out register.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write (valid only with `mem_req`).
- `reg_write`  out  1  register-file write enable.
- `alu_src_a`  out  2  ALU A select: 0 = PC, 1 = old PC, 2 = rs1.
- `alu_src_b`  out  2  ALU B select: 0 = rs2, 1 = immediate, 2 = constant 4.
- `alu_op`  out  2  ALU operation: 0 = add, 1 = subtract, 2 = funct-decoded.
- `result_src`  out  2  result select: 0 = ALU-out register, 1 = memory data, 2 = live ALU result.
- `illegal_instr`  out  1  sticky illegal-opcode flag.
- `state_dbg`  out  4  current state encoding.

## Operation
- Supported opcodes: LW 0000011, SW 0100011, R-type 0110011, I-ALU 0010011, branch 1100011, JAL 1101111. Every other opcode is illegal.
- Each state, its outputs (unlisted outputs are 0) and its next state:
  - **FETCH**: `mem_req`=1, `adr_src`=0, A=0, B=2, add, `result_src`=2.
    - `mem_ready`=1: assert `ir_write`=1 and `pc_write`=1, go to DECODE.
    - `mem_ready`=0: stay in FETCH with no writes.
  - **DECODE**: A=1, B=1, add (precomputes the branch target). Next state is chosen by opcode:
    - LW or SW → MEM_ADR.
    - R-type → EXEC_R.
    - I-ALU → EXEC_I.
    - branch → BRANCH.
    - JAL → JAL.
    - illegal opcode → see Configuration.
  - **MEM_ADR**: A=2, B=1, add. Go to MEM_READ for LW, MEM_WRITE for SW.
  - **MEM_READ**: `mem_req`=1, `adr_src`=1. Wait for `mem_ready`, then go to MEM_WB.
  - **MEM_WB**: `result_src`=1, `reg_write`=1, go to FETCH.
  - **MEM_WRITE**: `mem_req`=1, `mem_we`=1, `adr_src`=1. Wait for `mem_ready`, then go to FETCH.
  - **EXEC_R**: A=2, B=0, op=2, go to ALU_WB.
  - **EXEC_I**: A=2, B=1, op=2, go to ALU_WB.
  - **ALU_WB**: `result_src`=0, `reg_write`=1, go to FETCH.
  - **BRANCH**: A=2, B=0, op=1, `result_src`=0, `pc_write` = `zero` XOR `funct3[0]` (BEQ/BNE), go to FETCH.
  - **JAL**: A=1, B=2, add, `result_src`=0, `pc_write`=1, go to ALU_WB.
  - **TRAP**: only exists when the trap feature is compiled in; see Configuration.
- Outputs are decoded from state only. The exceptions are `ir_write`/`pc_write`, which are gated by `mem_ready` in FETCH and by `zero` in BRANCH.

## Timing
- **Reset:**
  - While `reset`=1, every output is 0 and `state_dbg` reads the FETCH encoding (0).
  - The first FETCH request is issued in the first cycle after `reset` falls.
- **Reset mid-operation:** the state returns to FETCH at the next edge and no write enable is asserted in the reset cycle. An outstanding memory request is abandoned.
- **Instruction latency** (FETCH through the final state, with `mem_ready` tied 1): LW 5 cycles, SW 4, R/I 4, branch 3, JAL 4.
- **Wait states:** each cycle `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. `mem_req`, `adr_src` and `mem_we` stay stable while waiting.
- **`illegal_instr`:** registered, reset to 0.

## Configuration
- Macro: `CTRL_ILLEGAL_TRAP_EN`.
- **Defined:**
  - An illegal opcode in DECODE goes to TRAP.
  - `illegal_instr` goes to 1 one cycle later.
  - TRAP holds all enables at 0 until reset.
- **Undefined:**
  - An illegal opcode goes DECODE → FETCH with no writes; PC has already advanced, so the instruction executes as a NOP.
  - `illegal_instr` is tied to 0 and the TRAP state does not exist.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum (4-bit);
  - the opcode localparams;
  - the encodings for `alu_src_a`, `alu_src_b`, `result_src` and `alu_op`.
- One sub-module, `ctrl_next_state`: the purely combinational next-state decode from state, opcode and `mem_ready`. Output decode and the state register remain in `multicycle_controller`.

## Test plan
- **Reset then R-type:** release reset with opcode 0110011 and `mem_ready`=1 → states FETCH, DECODE, EXEC_R, ALU_WB, FETCH; `ir_write` high only in cycle 1; `reg_write` high only in cycle 4.
- **LW with wait:** opcode 0000011, `mem_ready` held low for 2 cycles in MEM_READ → `mem_req`=1 and `adr_src`=1 held stable for 3 cycles; MEM_WB reached on cycle 7 with `result_src`=1.
- **Branch:**
  - BEQ (funct3=000) with `zero`=1 → `pc_write`=1 in BRANCH.
  - BNE (funct3=001) with `zero`=1 → `pc_write`=0.
- **JAL:** opcode 1101111 → `pc_write`=1 in JAL, then `reg_write`=1 in ALU_WB; 4 cycles total.
- **Illegal opcode:** opcode 1111111.
  - With `CTRL_ILLEGAL_TRAP_EN` → TRAP; `illegal_instr`=1; `mem_req` remains 0 for 10 cycles.
  - Without the macro → back to FETCH with `illegal_instr`=0.
- **Reset mid-SW:** assert `reset` during MEM_WRITE → `mem_we`=0 in that cycle; FETCH after release.
